// File: rtl/vga_frame_buff_paged.sv
// vga_frame_buff_paged: paged VGA frame buffer, AXI4-Lite CPU port plus a 1-cycle pixel read port.
// Define VGA_FB_FILL_EN to include the hardware page-fill engine (FILL register, CTRL.FILL_GO/FILL_BUSY).
module vga_frame_buff_paged #(
  parameter int PIXEL_WIDTH    = 640,
  parameter int PIXEL_HEIGHT   = 480,
  parameter int PIXEL_DEPTH    = 8,
  parameter int NUM_PAGES      = 2,
  parameter int AXI_DATA_WIDTH = 32,
  localparam int PAD            = (PIXEL_DEPTH <= 8) ? 8 : ((PIXEL_DEPTH <= 16) ? 16 : 32),
  localparam int PPW            = 32 / PAD,
  localparam int NPIX           = PIXEL_WIDTH * PIXEL_HEIGHT,
  localparam int PAGE_WORDS     = (NPIX + PPW - 1) / PPW,
  localparam int PW             = $clog2(PAGE_WORDS),
  localparam int AXI_ADDR_WIDTH = PW + 4,
  localparam int PXA            = $clog2(NPIX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PXA-1:0]              px_addr,
  output logic [PIXEL_DEPTH-1:0]      px_data,
  input  logic                        vsync,
  output logic                        front,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rvalid,
  input  logic                        axi_rready
);
  localparam int LSH   = $clog2(PPW);
  localparam int LW    = (LSH == 0) ? 1 : LSH;
  localparam int DEPTH = NUM_PAGES * PAGE_WORDS;
  localparam int RW    = $clog2(DEPTH);
  localparam bit TWO_PAGES = (NUM_PAGES == 2);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef VGA_FB_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  function automatic logic addr_err(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [PW:0] word;
    logic        e;
    word = {1'b0, a[PW+1:2]};
    if (a[1:0] != 2'b00)
      e = 1'b1;
    else if (a[PW+3])
      e = !((a[PW+2:2] == (PW+1)'(0)) || (FILL_EN && (a[PW+2:2] == (PW+1)'(1))));
    else
      e = (word >= PAGE_WORDS[PW:0]) || (a[PW+2] && !TWO_PAGES);
    return e;
  endfunction

  // {page, word} -> flat RAM index
  function automatic logic [RW-1:0] ram_idx(input logic [PW:0] pw);
    return RW'(pw[PW-1:0]) + (pw[PW] ? RW'(PAGE_WORDS) : RW'(0));
  endfunction

  logic [31:0]               mem [0:DEPTH-1];
  logic                      awready_r, wready_r, bvalid_r, aw_have_r, w_have_r;
  logic [1:0]                bresp_r, rresp_r;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_r, ar_addr_r;
  logic [31:0]               w_data_r, rdata_r, pa_q_r, reg_rdata_s, pb_wdata_s;
  logic [3:0]                w_strb_r, pb_we_s;
  logic                      arready_r, ar_have_r, rvalid_r, front_r, flip_pend_r;
  logic [LW-1:0]             lane_r, pa_lane_s;
  logic [RW-1:0]             pa_idx_s, pb_idx_s, fill_idx_s;
  logic [4:0]                lane_off_s;
  logic                      wr_fire_s, wr_err_s, wr_reg_s, ctrl_wr_s, fill_reg_wr_s;
  logic                      rd_issue_s, rd_err_s, flip_now_s, fill_step_s, fill_busy_s;
  logic [31:0]               fill_word_s;

  assign wr_fire_s     = aw_have_r & w_have_r;
  assign wr_err_s      = addr_err(aw_addr_r);
  assign wr_reg_s      = aw_addr_r[PW+3];
  assign ctrl_wr_s     = wr_fire_s & ~wr_err_s & wr_reg_s & (aw_addr_r[PW+2:2] == (PW+1)'(0));
  assign fill_reg_wr_s = wr_fire_s & ~wr_err_s & wr_reg_s & (aw_addr_r[PW+2:2] == (PW+1)'(1));
  assign rd_issue_s    = ar_have_r & ~rvalid_r & ~wr_fire_s;
  assign rd_err_s      = addr_err(ar_addr_r);
  assign flip_now_s    = vsync & flip_pend_r & ~fill_busy_s;
  assign fill_step_s   = fill_busy_s & ~wr_fire_s & ~rd_issue_s;

  assign pa_idx_s   = (front_r ? RW'(PAGE_WORDS) : RW'(0)) + RW'(px_addr / PXA'(PPW));
  assign pa_lane_s  = LW'(px_addr % PXA'(PPW));
  assign lane_off_s = 5'(int'(lane_r) * PAD);
  assign px_data    = pa_q_r[lane_off_s +: PIXEL_DEPTH];
  assign front      = front_r;

  assign axi_awready = awready_r;
  assign axi_wready  = wready_r;
  assign axi_bvalid  = bvalid_r;
  assign axi_bresp   = bresp_r;
  assign axi_arready = arready_r;
  assign axi_rvalid  = rvalid_r;
  assign axi_rresp   = rresp_r;
  assign axi_rdata   = rdata_r;

  // register readback mux
  always_comb begin
    reg_rdata_s = 32'h0;
    if (ar_addr_r[PW+2:2] == (PW+1)'(1))
      reg_rdata_s = fill_word_s;
    else
      reg_rdata_s = {28'h0, fill_busy_s, 1'b0, flip_pend_r, front_r};
  end

  // port-B arbitration: AXI write first, fill only in cycles nothing else needs the port
  always_comb begin
    pb_we_s    = 4'h0;
    pb_idx_s   = ram_idx(aw_addr_r[PW+2:2]);
    pb_wdata_s = w_data_r;
    if (wr_fire_s && !wr_err_s && !wr_reg_s) begin
      pb_we_s = w_strb_r;
    end else if (fill_step_s) begin
      pb_we_s    = 4'hF;
      pb_idx_s   = fill_idx_s;
      pb_wdata_s = fill_word_s;
    end else begin
      pb_we_s = 4'h0;
    end
  end

  // RAM port B byte-enable write; contents survive reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (pb_we_s[b]) mem[pb_idx_s][8*b +: 8] <= pb_wdata_s[8*b +: 8];
  end

  // RAM port A pixel read with its lane index registered alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      pa_q_r <= 32'h0;
      lane_r <= LW'(0);
    end else begin
      pa_q_r <= mem[pa_idx_s];
      lane_r <= pa_lane_s;
    end
  end

  // AXI channel handshakes, read issue and page flip
  always_ff @(posedge clk) begin
    if (rst) begin
      awready_r <= 1'b1; wready_r <= 1'b1; bvalid_r <= 1'b0; bresp_r <= OKAY;
      aw_have_r <= 1'b0; w_have_r <= 1'b0;
      aw_addr_r <= '0; w_data_r <= 32'h0; w_strb_r <= 4'h0;
      arready_r <= 1'b1; ar_have_r <= 1'b0; ar_addr_r <= '0;
      rvalid_r <= 1'b0; rresp_r <= OKAY; rdata_r <= 32'h0;
      front_r <= 1'b0; flip_pend_r <= 1'b0;
    end else begin
      if (axi_awvalid && awready_r) begin
        aw_addr_r <= axi_awaddr; aw_have_r <= 1'b1; awready_r <= 1'b0;
      end
      if (axi_wvalid && wready_r) begin
        w_data_r <= axi_wdata; w_strb_r <= axi_wstrb; w_have_r <= 1'b1; wready_r <= 1'b0;
      end
      if (wr_fire_s) begin
        aw_have_r <= 1'b0; w_have_r <= 1'b0; bvalid_r <= 1'b1;
        bresp_r <= wr_err_s ? SLVERR : OKAY;
      end else if (bvalid_r && axi_bready) begin
        bvalid_r <= 1'b0; awready_r <= 1'b1; wready_r <= 1'b1;
      end
      if (axi_arvalid && arready_r) begin
        ar_addr_r <= axi_araddr; ar_have_r <= 1'b1; arready_r <= 1'b0;
      end
      if (rd_issue_s) begin
        ar_have_r <= 1'b0; rvalid_r <= 1'b1;
        rresp_r <= rd_err_s ? SLVERR : OKAY;
        rdata_r <= rd_err_s ? 32'h0 : (ar_addr_r[PW+3] ? reg_rdata_s : mem[ram_idx(ar_addr_r[PW+2:2])]);
      end else if (rvalid_r && axi_rready) begin
        rvalid_r <= 1'b0; arready_r <= 1'b1;
      end
      if (flip_now_s) begin
        front_r <= ~front_r; flip_pend_r <= 1'b0;
      end
      // a FLIP write landing on a vsync cycle re-arms for the next vsync
      if (ctrl_wr_s && w_data_r[1] && TWO_PAGES) flip_pend_r <= 1'b1;
    end
  end

`ifdef VGA_FB_FILL_EN
  logic [31:0]   fill_word_r;
  logic          fill_busy_r, fill_page_r;
  logic [PW-1:0] fill_cnt_r;

  // fill engine: walks the back page in ascending word order
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_word_r <= 32'h0; fill_busy_r <= 1'b0; fill_page_r <= 1'b0; fill_cnt_r <= PW'(0);
    end else begin
      if (fill_reg_wr_s) fill_word_r <= w_data_r;
      if (fill_busy_r) begin
        if (fill_step_s) begin
          if (fill_cnt_r == PW'(PAGE_WORDS - 1)) fill_busy_r <= 1'b0;
          fill_cnt_r <= fill_cnt_r + PW'(1);
        end
      end else if (ctrl_wr_s && w_data_r[2]) begin
        fill_busy_r <= 1'b1;
        fill_cnt_r  <= PW'(0);
        fill_page_r <= TWO_PAGES ? ~(front_r ^ flip_now_s) : 1'b0;
      end
    end
  end

  assign fill_busy_s = fill_busy_r;
  assign fill_word_s = fill_word_r;
  assign fill_idx_s  = RW'(fill_cnt_r) + (fill_page_r ? RW'(PAGE_WORDS) : RW'(0));
`else
  assign fill_busy_s = 1'b0;
  assign fill_word_s = 32'h0;
  assign fill_idx_s  = RW'(0);
`endif

endmodule

// File: tb/tb_vga_frame_buff_paged.sv
// Scoreboard bench for vga_frame_buff_paged: 10x4 pixels, 8 bpp, 2 pages (10 words per page).
module tb_vga_frame_buff_paged;
  localparam int NP = 2, PWORDS = 10;
  localparam int CTRL_A = 128, FILL_A = 132;
`ifdef VGA_FB_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic clk = 1'b0, rst, vsync, front;
  logic [5:0] px_addr;
  logic [7:0] px_data, awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  vga_frame_buff_paged #(.PIXEL_WIDTH(10), .PIXEL_HEIGHT(4), .PIXEL_DEPTH(8), .NUM_PAGES(NP),
                         .AXI_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .px_addr(px_addr), .px_data(px_data), .vsync(vsync), .front(front),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready));

  initial forever #5 clk = ~clk;

  typedef struct { logic [1:0] resp; logic [31:0] data; } rsp_t;
  typedef struct { logic [7:0] px; logic f; } px_t;
  rsp_t bq[$], rq[$];
  px_t  pxq[$];
  int checks = 0, failures = 0, px_issued = 0;
  bit rand_rdy = 1'b0, skew_en = 1'b1;

  // reference model state
  logic [31:0] mem_m [0:NP*PWORDS-1];
  logic [31:0] fill_m = 32'h0;
  bit front_m = 1'b0, pend_m = 1'b0, busy_m = 1'b0, fpage_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++; failures++;
    $display("FAIL %s", name);
  endtask

  // 0 = error, 1 = pixel memory, 2 = CTRL, 3 = FILL
  function automatic int m_kind(input int a, output int idx);
    idx = 0;
    if (a % 4 != 0) return 0;
    if (a >= 128) begin
      if (a == CTRL_A) return 2;
      if (a == FILL_A && FILL_EN) return 3;
      return 0;
    end
    if (a / 64 >= NP) return 0;
    if ((a % 64) / 4 >= PWORDS) return 0;
    idx = (a / 64) * PWORDS + (a % 64) / 4;
    return 1;
  endfunction

  task automatic wait_drain();
    for (int n = 0; n < 200 && (bq.size() + rq.size() + pxq.size()) != 0; n++) @(negedge clk);
    if ((bq.size() + rq.size() + pxq.size()) != 0) begin
      note_fail("drain_timeout");
      bq.delete(); rq.delete(); pxq.delete();
    end
  endtask

  task automatic axi_write(input int a, input logic [31:0] d, input logic [3:0] s);
    int idx, k, wdly;
    bit hs_aw, hs_w;
    rsp_t r;
    k = m_kind(a, idx);
    r.data = 32'h0;
    r.resp = (k == 0) ? 2'b10 : 2'b00;
    if (k == 1) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
    end else if (k == 2) begin
      if (NP == 2 && d[1]) pend_m = 1'b1;
      if (FILL_EN && d[2] && !busy_m) begin busy_m = 1'b1; fpage_m = !front_m; end
    end else if (k == 3) begin
      fill_m = d;
    end
    bq.push_back(r);
    @(posedge clk); #1;
    awaddr = 8'(a); wdata = d; wstrb = s; awvalid = 1'b1;
    wdly = skew_en ? $urandom_range(0, 2) : 0;
    wvalid = (wdly == 0);
    for (int n = 0; n < 60 && (awvalid || wvalid || wdly > 0); n++) begin
      @(negedge clk);
      hs_aw = awvalid && awready; hs_w = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w) wvalid = 1'b0;
      if (wdly > 0) begin wdly--; if (wdly == 0) wvalid = 1'b1; end
    end
    if (awvalid || wvalid) begin
      note_fail("write_handshake_timeout");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    wait_drain();
  endtask

  task automatic axi_read(input int a);
    int idx, k;
    bit hs;
    rsp_t r;
    k = m_kind(a, idx);
    r.resp = (k == 0) ? 2'b10 : 2'b00;
    case (k)
      1: r.data = mem_m[idx];
      2: r.data = {28'h0, busy_m, 1'b0, pend_m, front_m};
      3: r.data = fill_m;
      default: r.data = 32'h0;
    endcase
    rq.push_back(r);
    @(posedge clk); #1;
    araddr = 8'(a); arvalid = 1'b1;
    for (int n = 0; n < 60 && arvalid; n++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      if (hs) arvalid = 1'b0;
    end
    if (arvalid) begin note_fail("read_handshake_timeout"); arvalid = 1'b0; end
    wait_drain();
  endtask

  task automatic px_check(input int i);
    px_t p;
    logic [31:0] w;
    w = mem_m[(front_m ? PWORDS : 0) + i / 4];
    p.px = w[8*(i % 4) +: 8];
    p.f = front_m;
    @(posedge clk); #1;
    pxq.push_back(p);
    px_addr = 6'(i);
    px_issued++;
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    if (pend_m && !busy_m) begin front_m = !front_m; pend_m = 1'b0; end
  endtask

  // ready driver
  initial begin
    bready = 1'b1; rready = 1'b1;
    forever begin
      @(posedge clk); #2;
      bready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a response or a pixel
  initial begin
    rsp_t r;
    px_t p;
    logic [31:0] hold_d = 32'h0;
    bit hold = 1'b0, armed = 1'b0;
    int taken = 0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) begin
        if (bq.size() == 0) note_fail("unexpected_bresp");
        else begin r = bq.pop_front(); chk("bresp", 32'(bresp), 32'(r.resp)); end
      end
      if (hold && rvalid) chk("rdata_hold", rdata, hold_d);
      hold = rvalid && !rready;
      hold_d = rdata;
      if (rvalid && rready) begin
        if (rq.size() == 0) note_fail("unexpected_rresp");
        else begin
          r = rq.pop_front();
          chk("rresp", 32'(rresp), 32'(r.resp));
          chk("rdata", rdata, r.data);
        end
      end
      if (armed) begin
        if (pxq.size() == 0) note_fail("px_queue_empty");
        else begin
          p = pxq.pop_front();
          chk("px_data", 32'(px_data), 32'(p.px));
          chk("front", 32'(front), 32'(p.f));
        end
      end
      armed = (px_issued != taken);
      taken = px_issued;
    end
  end

  initial begin
    int a, k;
    logic [31:0] d;
    rst = 1'b1; vsync = 1'b0; px_addr = 6'h0;
    awaddr = 8'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    araddr = 8'h0; arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'h1);
    chk("rst_wready", 32'(wready), 32'h1);
    chk("rst_arready", 32'(arready), 32'h1);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_px_data", 32'(px_data), 32'h0);
    chk("rst_front", 32'(front), 32'h0);

    axi_read(CTRL_A);
    axi_write(0, 32'h44332211, 4'hF);
    for (int i = 0; i < 4; i++) px_check(i);
    wait_drain();
    axi_write(64, 32'h000000AA, 4'hF);
    axi_write(CTRL_A, 32'h2, 4'hF);
    vsync_pulse();
    px_check(0);
    wait_drain();
    axi_read(2);
    axi_read(PWORDS * 4);
    axi_read(0);
    axi_write(0, 32'hFFFFFFFF, 4'h2);
    axi_read(0);

    for (int i = 1; i < PWORDS; i++) begin
      axi_write(i * 4, $urandom, 4'hF);
      axi_write(64 + i * 4, $urandom, 4'hF);
    end

    rand_rdy = 1'b1;
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 5);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : 4 * $urandom_range(0, 31);
      case (k)
        0: axi_write(a, $urandom, 4'($urandom_range(0, 15)));
        1: axi_read(a);
        2: begin
          for (int j = 0; j < 3; j++) px_check($urandom_range(0, 39));
          wait_drain();
        end
        3: begin
          d = $urandom;
          if (FILL_EN) d[2] = 1'b0;
          axi_write(CTRL_A, d, 4'hF);
          if ($urandom_range(0, 1) == 1) vsync_pulse();
        end
        4: vsync_pulse();
        default: begin
          a = CTRL_A + 4 * $urandom_range(0, 3);
          d = $urandom;
          if (a == CTRL_A && FILL_EN) d[2] = 1'b0;
          if ($urandom_range(0, 1) == 1) axi_write(a, d, 4'hF);
          else axi_read(a);
        end
      endcase
    end

`ifdef VGA_FB_FILL_EN
    rand_rdy = 1'b0;
    skew_en = 1'b0;
    axi_write(FILL_A, 32'h5A5A5A5A, 4'hF);
    axi_write(CTRL_A, 32'h4, 4'hF);
    axi_write(CTRL_A, 32'h2, 4'hF);
    vsync_pulse();
    px_check(0);
    wait_drain();
    repeat (30) @(posedge clk);
    for (int i = 0; i < PWORDS; i++) mem_m[(fpage_m ? PWORDS : 0) + i] = fill_m;
    busy_m = 1'b0;
    axi_read(CTRL_A);
    vsync_pulse();
    px_check(5);
    wait_drain();
    for (int i = 0; i < PWORDS; i++) axi_read((fpage_m ? 64 : 0) + 4 * i);
`else
    axi_write(FILL_A, 32'h12345678, 4'hF);
    axi_read(FILL_A);
    axi_write(CTRL_A, 32'hC, 4'hF);
    axi_read(CTRL_A);
`endif

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
